updown_step_decoder: RTL and testbench
======================================

Name: updown_step_decoder

Overview:
- Receive-side partner of the 2-bit up/down counter FSM. Samples the counter's 2-bit state output every clock and infers the step direction.
- Accumulates a wide signed-free position, flags stalls, and flags illegal 2-step jumps.
- Sits downstream of the counter, where the wide position, step pulses and error flags are consumed by display and checking logic.

Parameters:
- POS_W, 8, width of the position accumulator (wraps mod 2^POS_W).
- HOLD_LIMIT, 4, consecutive unchanged compares before stalled asserts (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_in  input  2  sampled state from the upstream 2-bit up/down counter.
- err_clr  input  1  clears fault and resumes tracking; used only in FAULT.
- pos  output  POS_W  accumulated position.
- dir  output  1  last step direction: 0 = value +1 mod 4, 1 = value -1 mod 4. Matches the counter's UpDown encoding.
- step  output  1  one-cycle pulse per accepted step.
- stalled  output  1  cnt_in unchanged for HOLD_LIMIT compares.
- fault  output  1  sticky illegal-jump flag.

Behaviour:
- Reset has priority over everything, in every state.
  - Next edge after reset: pos=0, dir=0, step=0, stalled=0, fault=0, prev=0, hold_cnt=0, state=ACQ.
- All outputs are registered. cnt_in is sampled at edge N and compared with prev, the value sampled at edge N-1. Results are visible after edge N, so latency is 1 clock.
- delta = (cnt_in - prev) mod 4.
- ACQ:
  - prev<=cnt_in; go to TRACK.
  - No step, pos unchanged, stalled=0.
  - The first sample after reset never counts as a step.
- TRACK, delta=1: pos<=pos+1 (wraps max->0), dir<=0, step<=1, hold_cnt<=0, stalled<=0.
- TRACK, delta=3: pos<=pos-1 (wraps 0->max), dir<=1, step<=1, hold_cnt<=0, stalled<=0.
- TRACK, delta=0:
  - step<=0; hold_cnt increments, saturating at HOLD_LIMIT.
  - stalled<=1 on the compare where hold_cnt reaches HOLD_LIMIT; it stays high until the next accepted step.
  - dir holds its value.
- TRACK, delta=2 (illegal jump): fault<=1, step<=0, pos unchanged, go to FAULT.
- prev<=cnt_in on every edge in TRACK and FAULT.
- FAULT:
  - pos, dir and stalled are frozen; step=0; hold_cnt=0.
  - cnt_in changes are ignored except for updating prev.
  - err_clr=1: fault<=0, go to TRACK. The next compare uses the prev captured on the err_clr edge, so there is no spurious step.
- err_clr is ignored in ACQ and TRACK.
- step is never high on two consecutive cycles unless cnt_in changes on two consecutive edges. A legal +1/-1 change every clock produces a step every clock.
- Default state encoding or unreachable state: go to ACQ.

Optional Feature:
- Macro: UPDOWN_STEP_DECODER_OVF_EN.
- When defined:
  - Adds output pos_ovf (1 bit), reset 0.
  - Set sticky when pos wraps in either direction (max->0 on delta=1, 0->max on delta=3).
  - Cleared by err_clr in any state, or by reset.
- When undefined: port and logic are absent; wrap is silent.

Test Plan:
- Up count: reset 1 cycle, cnt_in=0 for 2 clocks, then 1,2,3,0 on successive clocks -> 4 step pulses, dir=0, pos=4, fault=0.
- Down count: continue from pos=4, cnt_in 0,3,2,1 -> 3 step pulses, dir=1, pos=1.
- Stall: hold cnt_in=1 for 5 clocks (HOLD_LIMIT=4) -> stalled=1 after the 4th unchanged compare; then cnt_in=2 -> stalled=0, step=1, pos=2.
- Fault: in TRACK, cnt_in 0->2 -> fault=1, step=0, pos unchanged. Then cnt_in 3,0 -> no steps. err_clr=1 with cnt_in=0, then cnt_in=1 -> fault=0, one step, pos+1.
- Wrap: pos=0, cnt_in 1->0 -> pos=255, dir=1. With UPDOWN_STEP_DECODER_OVF_EN, pos_ovf=1 until err_clr.
- Mid-operation reset: assert reset while cnt_in toggles -> all outputs 0 next edge. After release, first sample (cnt_in=3) produces no step; next cnt_in=0 -> step=1, dir=0, pos=1.

Source files
------------

// File: rtl/updown_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : updown_step_decoder
// Description : Receive-side decoder for a 2-bit up/down counter. Samples the
//               counter state every clock, infers +1/-1 steps, accumulates a
//               wrapping position, flags stalls and latches illegal 2-step
//               jumps until cleared by err_clr.
// Option      : UPDOWN_STEP_DECODER_OVF_EN adds the sticky pos_ovf output,
//               set whenever pos wraps in either direction.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_step_decoder #(
  parameter int POS_W      = 8,
  parameter int HOLD_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cnt_in,
  input  logic             err_clr,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             stalled,
  output logic             fault
`ifdef UPDOWN_STEP_DECODER_OVF_EN
  ,
  output logic             pos_ovf
`endif
);

  // HOLD_LIMIT is clamped into the range the 8-bit hold counter can represent.
  localparam int HOLD_CLAMP = (HOLD_LIMIT < 1)   ? 1   :
                              (HOLD_LIMIT > 255) ? 255 : HOLD_LIMIT;
  localparam logic [7:0]       HOLD_MAX = 8'(HOLD_CLAMP);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX  = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] POS_MIN  = '0;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       prev;
  logic [7:0]       hold_cnt;

  logic [POS_W-1:0] pos_nxt;
  logic             dir_nxt;
  logic             step_nxt;
  logic             stalled_nxt;
  logic             fault_nxt;
  logic [7:0]       hold_nxt;
  logic [1:0]       delta;
  logic             wrap_up;
  logic             wrap_dn;

  // Modular distance from the previous sample; 2-bit subtraction wraps mod 4.
  assign delta   = cnt_in - prev;
  assign wrap_up = (pos == POS_MAX);
  assign wrap_dn = (pos == POS_MIN);

`ifdef UPDOWN_STEP_DECODER_OVF_EN
  logic ovf_nxt;

  // Sticky wrap flag: set on any accepted step that wraps, cleared by err_clr
  // in every state (clear wins over a simultaneous wrap).
  always_comb begin
    ovf_nxt = pos_ovf;
    if (state == TRACK) begin
      if ((delta == 2'd1 && wrap_up) || (delta == 2'd3 && wrap_dn)) begin
        ovf_nxt = 1'b1;
      end
    end
    if (err_clr) begin
      ovf_nxt = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_ovf <= 1'b0;
    end else begin
      pos_ovf <= ovf_nxt;
    end
  end
`endif

  // Next-state and next-output decode; every target gets a default first.
  always_comb begin
    state_nxt   = state;
    pos_nxt     = pos;
    dir_nxt     = dir;
    step_nxt    = 1'b0;
    stalled_nxt = stalled;
    fault_nxt   = fault;
    hold_nxt    = hold_cnt;

    case (state)
      // First sample after reset only seeds prev; it can never be a step.
      ACQ: begin
        stalled_nxt = 1'b0;
        hold_nxt    = 8'd0;
        state_nxt   = TRACK;
      end

      TRACK: begin
        case (delta)
          2'd1: begin
            pos_nxt     = pos + POS_ONE;
            dir_nxt     = 1'b0;
            step_nxt    = 1'b1;
            hold_nxt    = 8'd0;
            stalled_nxt = 1'b0;
          end
          2'd3: begin
            pos_nxt     = pos - POS_ONE;
            dir_nxt     = 1'b1;
            step_nxt    = 1'b1;
            hold_nxt    = 8'd0;
            stalled_nxt = 1'b0;
          end
          2'd0: begin
            // Saturating hold count; stalled rises on the compare that
            // reaches the limit and stays until the next accepted step.
            if (hold_cnt < HOLD_MAX) begin
              hold_nxt = hold_cnt + 8'd1;
              if (hold_cnt + 8'd1 == HOLD_MAX) begin
                stalled_nxt = 1'b1;
              end
            end
          end
          default: begin
            // A 2-step jump means the sampler missed a transition.
            fault_nxt = 1'b1;
            hold_nxt  = 8'd0;
            state_nxt = FAULT;
          end
        endcase
      end

      // Frozen until software acknowledges; prev keeps following cnt_in so
      // the first compare after the clear sees no spurious step.
      FAULT: begin
        hold_nxt = 8'd0;
        if (err_clr) begin
          fault_nxt = 1'b0;
          state_nxt = TRACK;
        end
      end

      default: begin
        state_nxt = ACQ;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACQ;
      prev     <= 2'd0;
      hold_cnt <= 8'd0;
      pos      <= '0;
      dir      <= 1'b0;
      step     <= 1'b0;
      stalled  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev     <= cnt_in;
      hold_cnt <= hold_nxt;
      pos      <= pos_nxt;
      dir      <= dir_nxt;
      step     <= step_nxt;
      stalled  <= stalled_nxt;
      fault    <= fault_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_step_decoder
// Description : Self-checking bench for updown_step_decoder. A behavioural
//               model tracks the expected outputs from the decoding rules and
//               is compared against the DUT every cycle; directed literal
//               checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_step_decoder;

  localparam int POS_W = 8;
  localparam int HOLD  = 4;
  localparam int MODV  = 1 << POS_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       cnt_in;
  logic             err_clr;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic             step;
  logic             stalled;
  logic             fault;
`ifdef UPDOWN_STEP_DECODER_OVF_EN
  logic             pos_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int steps_seen = 0;

  // Model state: phase 0 = acquiring, 1 = tracking, 2 = faulted.
  int m_phase, m_prev, m_pos, m_dir, m_step, m_stall, m_fault, m_same, m_ovf;
  bit m_valid = 1'b0;

  updown_step_decoder #(.POS_W(POS_W), .HOLD_LIMIT(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_in  (cnt_in),
    .err_clr (err_clr),
    .pos     (pos),
    .dir     (dir),
    .step    (step),
    .stalled (stalled),
    .fault   (fault)
`ifdef UPDOWN_STEP_DECODER_OVF_EN
    ,
    .pos_ovf (pos_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the decoding rules for one clock edge.
  task automatic model_edge(input int c, input bit r, input bit e);
    int d;
    if (r) begin
      m_phase = 0; m_prev = 0; m_pos = 0; m_dir = 0; m_step = 0;
      m_stall = 0; m_fault = 0; m_same = 0; m_ovf = 0;
      return;
    end
    m_step = 0;
    if (m_phase == 0) begin
      m_phase = 1; m_stall = 0; m_same = 0;
    end else if (m_phase == 1) begin
      d = (c - m_prev + 4) % 4;
      if (d == 1) begin
        if (m_pos == MODV - 1) m_ovf = 1;
        m_pos = (m_pos + 1) % MODV;
        m_dir = 0; m_step = 1; m_same = 0; m_stall = 0;
      end else if (d == 3) begin
        if (m_pos == 0) m_ovf = 1;
        m_pos = (m_pos + MODV - 1) % MODV;
        m_dir = 1; m_step = 1; m_same = 0; m_stall = 0;
      end else if (d == 0) begin
        if (m_same < HOLD) begin
          m_same++;
          if (m_same == HOLD) m_stall = 1;
        end
      end else begin
        m_fault = 1; m_phase = 2; m_same = 0;
      end
    end else begin
      m_same = 0;
      if (e) begin
        m_fault = 0; m_phase = 1;
      end
    end
    if (e) m_ovf = 0;
    m_prev = c;
  endtask

  // Drive one clock: inputs set well away from the edge, model updated after.
  task automatic tick(input logic [1:0] c, input logic r = 1'b0, input logic e = 1'b0);
    cnt_in  = c;
    reset   = r;
    err_clr = e;
    @(posedge clk);
    model_edge(int'(c), r, e);
    if (r) m_valid = 1'b1;
    #1;
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pos",     int'(pos),     m_pos);
      chk("dir",     int'(dir),     m_dir);
      chk("step",    int'(step),    m_step);
      chk("stalled", int'(stalled), m_stall);
      chk("fault",   int'(fault),   m_fault);
`ifdef UPDOWN_STEP_DECODER_OVF_EN
      chk("pos_ovf", int'(pos_ovf), m_ovf);
`endif
      if (step) steps_seen++;
    end
  end

  initial begin
    int s0;
    reset = 1'b1; cnt_in = 2'd0; err_clr = 1'b0;
    tick(2'd0, 1'b1);
    chk("rst_pos", int'(pos), 0);
    chk("rst_flags", int'({dir, step, stalled, fault}), 0);

    // Up count: seed, one hold, then four +1 steps.
    tick(2'd0); tick(2'd0);
    #5 s0 = steps_seen; #1;
    tick(2'd1);
    chk("up_first_step", int'(step), 1);
    chk("up_first_pos", int'(pos), 1);
    tick(2'd2); tick(2'd3); tick(2'd0);
    #5; #1;
    chk("up_steps", steps_seen - s0, 4);
    chk("up_pos", int'(pos), 4);
    chk("up_dir", int'(dir), 0);
    chk("up_fault", int'(fault), 0);

    // Down count: hold at 0, then three -1 steps.
    s0 = steps_seen;
    tick(2'd0); tick(2'd3); tick(2'd2); tick(2'd1);
    #5; #1;
    chk("dn_steps", steps_seen - s0, 3);
    chk("dn_pos", int'(pos), 1);
    chk("dn_dir", int'(dir), 1);

    // Stall: four unchanged compares raise stalled.
    tick(2'd1); tick(2'd1); tick(2'd1);
    chk("stall_pre", int'(stalled), 0);
    tick(2'd1);
    chk("stall_set", int'(stalled), 1);
    tick(2'd1);
    chk("stall_hold", int'(stalled), 1);
    tick(2'd2);
    chk("stall_clr", int'(stalled), 0);
    chk("stall_step", int'(step), 1);
    chk("stall_pos", int'(pos), 2);

    // Fault: 0 -> 2 jump, ignored changes, clear, then one clean step.
    tick(2'd3); tick(2'd0);
    tick(2'd2);
    chk("flt_set", int'(fault), 1);
    chk("flt_step", int'(step), 0);
    chk("flt_pos", int'(pos), 4);
    s0 = steps_seen;
    tick(2'd3); tick(2'd0);
    tick(2'd0, 1'b0, 1'b1);
    chk("flt_clr", int'(fault), 0);
    tick(2'd1);
    #5; #1;
    chk("flt_resume_steps", steps_seen - s0, 1);
    chk("flt_resume_pos", int'(pos), 5);
    tick(2'd1, 1'b0, 1'b1);
    chk("clr_ignored_track", int'(pos), 5);

    // Wrap both ways from pos=0.
    tick(2'd0, 1'b1);
    tick(2'd1);
    tick(2'd0);
    chk("wrap_dn_pos", int'(pos), 255);
    chk("wrap_dn_dir", int'(dir), 1);
`ifdef UPDOWN_STEP_DECODER_OVF_EN
    chk("wrap_ovf_set", int'(pos_ovf), 1);
`endif
    tick(2'd1);
    chk("wrap_up_pos", int'(pos), 0);
    chk("wrap_up_dir", int'(dir), 0);
    tick(2'd1, 1'b0, 1'b1);
`ifdef UPDOWN_STEP_DECODER_OVF_EN
    chk("wrap_ovf_clr", int'(pos_ovf), 0);
`endif

    // Mid-operation reset while toggling.
    tick(2'd2); tick(2'd3);
    chk("mid_pre_pos", int'(pos), 2);
    tick(2'd0, 1'b1);
    chk("mid_rst_pos", int'(pos), 0);
    chk("mid_rst_flags", int'({dir, step, stalled, fault}), 0);
    tick(2'd3);
    chk("mid_acq_nostep", int'(step), 0);
    tick(2'd0);
    chk("mid_step", int'(step), 1);
    chk("mid_dir", int'(dir), 0);
    chk("mid_pos", int'(pos), 1);
    tick(2'd0); tick(2'd0);

    #5; #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
